boot_loader: RTL and testbench

- Upstream companion to the multicycle CPU. Receives a program image as a byte stream over a valid/ready handshake.
- Assembles 16-bit words and writes them into the unified instruction/data memory through the memory's write port.
- Holds the CPU in reset during the load; releases it only after the image checksum verifies.
- Afterwards watches the CPU Halt flag and reports completion.

---
 rtl/boot_loader.sv | 205 ++++++++++++++++++++
 tb/tb_boot_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: receives a byte-stream program image over valid/ready, packs
// big-endian 16-bit words into the CPU memory write port, holds the CPU in
// reset until the XOR checksum verifies, then reports when the CPU halts.
//
// Optional: define BOOT_TIMEOUT_EN to add an idle-byte watchdog. The loader
// errors out after TIMEOUT_CYC cycles without an accepted byte while it is
// waiting for input. Without the macro the loader waits for bytes forever.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | after reset, CPU held in reset, waiting for start
//   LEN_HI   | waiting for word-count high byte
//   LEN_LO   | waiting for word-count low byte, range-checks the count
//   DATA_HI  | waiting for data word high byte
//   DATA_LO  | waiting for data word low byte
//   WRITE    | single-cycle memory write of the assembled word
//   CHECK    | waiting for checksum byte
//   RUN      | CPU released, watching cpu_halt
//   HALTED   | CPU halted, done asserted, CPU left out of reset
//   ERROR    | bad length, bad checksum or timeout; CPU held in reset
module boot_loader #(
    parameter int ADDR_W      = 8,
    parameter int LOAD_BASE   = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_reset,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_t;

    // Largest image that fits between LOAD_BASE and the top of memory.
    localparam int MAX_WORDS = (1 << ADDR_W) - LOAD_BASE;

    state_t            r_state;
    state_t            w_next;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_cpu_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W:0]   r_words;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_len;
    logic [7:0]        r_data_hi;
    logic [7:0]        r_chk;

    logic              w_accept;
    logic [15:0]       w_len_new;
    logic              w_len_bad;
    logic              w_last_word;
    logic              w_start_load;
    logic              w_timeout;

    // in_ready is high exactly in the byte-waiting states.
    assign w_accept     = r_in_ready && in_valid;
    assign w_len_new    = {r_len_hi, in_data};
    assign w_len_bad    = {16'd0, w_len_new} > 32'(MAX_WORDS);
    assign w_last_word  = (17'(r_words) + 17'd1) == {1'b0, r_len};
    assign w_start_load = start &&
                          (r_state == S_IDLE || r_state == S_HALTED || r_state == S_ERROR);

`ifdef BOOT_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_to_cnt;

    // Terminal count reached with no byte arriving in a waiting state.
    assign w_timeout = r_in_ready && !w_accept && (r_to_cnt == '0);

    // Idle-byte down-counter, reloaded on every accepted byte and state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= TO_LOAD;
        end else if (w_accept || (w_next != r_state)) begin
            r_to_cnt <= TO_LOAD;
        end else if (r_in_ready && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - TO_W'(1);
        end
    end
`else
    // Watchdog compiled out; this term is constant false.
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    // Next-state selection from the current state and the handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALTED, S_ERROR: if (start) w_next = S_LEN_HI;
            S_LEN_HI:  if (w_accept) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_len_bad)              w_next = S_ERROR;
                    else if (w_len_new == '0)   w_next = S_CHECK;
                    else                        w_next = S_DATA_HI;
                end
            end
            S_DATA_HI: if (w_accept) w_next = S_DATA_LO;
            S_DATA_LO: if (w_accept) w_next = S_WRITE;
            S_WRITE:   w_next = w_last_word ? S_CHECK : S_DATA_HI;
            S_CHECK: begin
                if (w_accept) w_next = (in_data == r_chk) ? S_RUN : S_ERROR;
            end
            S_RUN:     if (cpu_halt) w_next = S_HALTED;
            default:   w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_ERROR;
    end

    // State register, registered outputs decoded from the next state, datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ADDR_W'(LOAD_BASE);
            r_mem_wdata <= 16'd0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_words     <= '0;
            r_len_hi    <= 8'd0;
            r_len       <= 16'd0;
            r_data_hi   <= 8'd0;
            r_chk       <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == S_LEN_HI)  || (w_next == S_LEN_LO) ||
                           (w_next == S_DATA_HI) || (w_next == S_DATA_LO) ||
                           (w_next == S_CHECK);
            r_busy      <= (w_next == S_LEN_HI)  || (w_next == S_LEN_LO) ||
                           (w_next == S_DATA_HI) || (w_next == S_DATA_LO) ||
                           (w_next == S_WRITE)   || (w_next == S_CHECK);
            r_mem_we    <= (w_next == S_WRITE);
            r_cpu_reset <= !((w_next == S_RUN) || (w_next == S_HALTED));
            r_done      <= (w_next == S_HALTED);
            r_error     <= (w_next == S_ERROR);

            if (w_start_load) begin
                r_chk   <= 8'd0;
                r_words <= '0;
            end else if (w_accept && (r_state != S_CHECK)) begin
                r_chk <= r_chk ^ in_data;
            end

            if (w_accept) begin
                case (r_state)
                    S_LEN_HI:  r_len_hi  <= in_data;
                    S_LEN_LO:  r_len     <= w_len_new;
                    S_DATA_HI: r_data_hi <= in_data;
                    S_DATA_LO: begin
                        r_mem_wdata <= {r_data_hi, in_data};
                        r_mem_addr  <= ADDR_W'(LOAD_BASE) + r_words[ADDR_W-1:0];
                    end
                    default: ;
                endcase
            end

            if (r_state == S_WRITE) begin
                r_words <= r_words + (ADDR_W+1)'(1);
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_reset    = r_cpu_reset;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: byte-indexed reference model of the image
// protocol, per-cycle output comparison, plus literal expectations for the
// directed images.
module tb_boot_loader;

    localparam int ADDR_W    = 8;
    localparam int LOAD_BASE = 0;
    localparam int TB_TO     = 64;
    localparam int MAXW      = (1 << ADDR_W) - LOAD_BASE;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_reset;
    logic              cpu_halt = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int failures = 0;

    boot_loader #(.ADDR_W(ADDR_W), .LOAD_BASE(LOAD_BASE), .TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .cpu_halt(cpu_halt), .busy(busy), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    initial forever #5 clk = ~clk;

    // ---------------- reference model (byte-index view of a load) ----------
    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_HALT, M_ERR} mphase_t;
    mphase_t           m_ph = M_IDLE;
    int                m_idx = 0;
    int                m_n = 0;
    int                m_words = 0;
    int                m_idle = 0;
    logic [7:0]        m_xor = 8'd0;
    logic [7:0]        m_hi = 8'd0;
    bit                m_wpend = 1'b0;
    logic [ADDR_W-1:0] m_addr = ADDR_W'(LOAD_BASE);
    logic [15:0]       m_wdata = 16'd0;

    task automatic model_accept(input logic [7:0] b);
        if (m_idx < 2) begin
            m_xor = m_xor ^ b;
            if (m_idx == 0) m_n = int'(b) * 256;
            else begin
                m_n = m_n + int'(b);
                if (m_n > MAXW) m_ph = M_ERR;
            end
        end else if (m_idx == 2 + 2 * m_n) begin
            m_ph = (b == m_xor) ? M_RUN : M_ERR;
        end else begin
            m_xor = m_xor ^ b;
            if (m_idx % 2 == 0) m_hi = b;
            else begin
                m_wpend = 1'b1;
                m_wdata = {m_hi, b};
                m_addr  = ADDR_W'(LOAD_BASE + m_words);
            end
        end
        m_idx++;
    endtask

    task automatic model_step();
        if (reset) begin
            m_ph = M_IDLE; m_idx = 0; m_n = 0; m_words = 0; m_idle = 0;
            m_xor = 8'd0; m_wpend = 1'b0;
            m_addr = ADDR_W'(LOAD_BASE); m_wdata = 16'd0;
        end else begin
            case (m_ph)
                M_IDLE, M_HALT, M_ERR: begin
                    if (start) begin
                        m_ph = M_LOAD; m_idx = 0; m_xor = 8'd0; m_words = 0; m_idle = 0;
                    end
                end
                M_RUN: if (cpu_halt) m_ph = M_HALT;
                M_LOAD: begin
                    if (m_wpend) begin
                        m_wpend = 1'b0; m_words++; m_idle = 0;
                    end else if (in_valid) begin
                        model_accept(in_data); m_idle = 0;
                    end else begin
                        m_idle++;
`ifdef BOOT_TIMEOUT_EN
                        if (m_idle >= TB_TO) m_ph = M_ERR;
`endif
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    logic [38:0] act_v, exp_v;
    initial begin
        @(negedge clk);
        forever begin
            act_v = {in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error, words_loaded};
            exp_v = {(m_ph == M_LOAD) && !m_wpend, m_wpend, m_addr, m_wdata,
                     !((m_ph == M_RUN) || (m_ph == M_HALT)), m_ph == M_LOAD,
                     m_ph == M_HALT, m_ph == M_ERR, (ADDR_W+1)'(m_words)};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, act_v, exp_v);
            end
            @(negedge clk);
        end
    end

    // DUT write log for literal checks.
    logic [ADDR_W-1:0] wlog_a[$];
    logic [15:0]       wlog_d[$];
    initial forever begin
        @(negedge clk);
        if (mem_we === 1'b1) begin
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic halt_cpu();
        @(negedge clk); cpu_halt = 1'b1;
        @(negedge clk); cpu_halt = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit sent = 1'b0;
        int guard = 0;
        while (!sent) begin
            @(negedge clk);
            start = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (rnd && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                sent     = in_ready;
            end
            guard++;
            if (guard > 200) begin
                failures++;
                $display("FAIL send_byte_timeout actual=in_ready_low expected=accept");
                break;
            end
        end
    endtask

    task automatic idle_bus();
        @(negedge clk); in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic send_image(input logic [7:0] img[$], input bit rnd);
        foreach (img[i]) send_byte(img[i], rnd);
        idle_bus();
    endtask

    task automatic check_image1_writes(input string tag);
        check({tag, "_nwrites"}, wlog_a.size(), 2);
        if (wlog_a.size() == 2) begin
            check({tag, "_addr0"}, wlog_a[0], 0);
            check({tag, "_data0"}, wlog_d[0], 16'h1234);
            check({tag, "_addr1"}, wlog_a[1], 1);
            check({tag, "_data1"}, wlog_d[1], 16'hABCD);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    logic [7:0] img1[$];
    logic [7:0] img[$];

    initial begin
        img1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_mem_addr", mem_addr, LOAD_BASE);
        check("rst_words", words_loaded, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed image with checksum-release latency.
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(img1[i], 1'b0);
        send_byte(8'h42, 1'b0);
        check("t1_cpu_reset_before", cpu_reset, 1);
        @(negedge clk); in_valid = 1'b0;
        check("t1_cpu_reset_after", cpu_reset, 0);
        check("t1_busy", busy, 0);
        check("t1_words", words_loaded, 2);
        check_image1_writes("t1");
        halt_cpu();
        check("t1_done", done, 1);

        // Bad checksum, then recovery.
        wlog_a.delete(); wlog_d.delete();
        img = img1; img[6] = 8'h43;
        pulse_start();
        send_image(img, 1'b0);
        check("t2_error", error, 1);
        check("t2_cpu_reset", cpu_reset, 1);
        pulse_start();
        send_image(img1, 1'b0);
        check("t2_rerun_cpu_reset", cpu_reset, 0);
        check("t2_rerun_error", error, 0);
        halt_cpu();

        // Zero-length image.
        wlog_a.delete(); wlog_d.delete();
        img = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_image(img, 1'b0);
        check("t3_cpu_reset", cpu_reset, 0);
        check("t3_nwrites", wlog_a.size(), 0);
        halt_cpu();

        // Oversize length 0x0101.
        img = '{8'h01, 8'h01};
        pulse_start();
        send_image(img, 1'b0);
        check("t4_error", error, 1);
        check("t4_busy", busy, 0);
        check("t4_nwrites", wlog_a.size(), 0);

        // Image 1 with random valid gaps.
        wlog_a.delete(); wlog_d.delete();
        pulse_start();
        send_image(img1, 1'b1);
        check_image1_writes("t5");
        check("t5_cpu_reset", cpu_reset, 0);
        halt_cpu();

        // Random images, some with corrupted checksum.
        for (int k = 0; k < 10; k++) begin
            int n;
            logic [7:0] x;
            n = $urandom_range(0, 6);
            img.delete();
            img.push_back(8'(n >> 8));
            img.push_back(8'(n));
            for (int j = 0; j < 2 * n; j++) img.push_back(8'($urandom));
            x = 8'd0;
            foreach (img[j]) x = x ^ img[j];
            if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            img.push_back(x);
            pulse_start();
            send_image(img, 1'b1);
            repeat (2) @(negedge clk);
            halt_cpu();
        end

        // Full-memory image (256 words).
        wlog_a.delete(); wlog_d.delete();
        img.delete();
        img.push_back(8'h01); img.push_back(8'h00);
        for (int j = 0; j < 512; j++) img.push_back(8'($urandom));
        begin
            logic [7:0] x;
            x = 8'd0;
            foreach (img[j]) x = x ^ img[j];
            img.push_back(x);
        end
        pulse_start();
        send_image(img, 1'b0);
        check("t6_words", words_loaded, 256);
        check("t6_cpu_reset", cpu_reset, 0);
        check("t6_nwrites", wlog_a.size(), 256);
        if (wlog_a.size() == 256) begin
            check("t6_last_addr", wlog_a[255], 255);
            check("t6_last_data", wlog_d[255], {img[512], img[513]});
        end
        halt_cpu();

        // Asynchronous reset in the middle of the data phase.
        img = '{8'h00, 8'h03, 8'h12, 8'h34};
        pulse_start();
        foreach (img[j]) send_byte(img[j], 1'b0);
        send_byte(8'h56, 1'b0);
        check("t7_words_before", words_loaded, 1);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("t7_async_in_ready", in_ready, 0);
        check("t7_async_busy", busy, 0);
        check("t7_async_cpu_reset", cpu_reset, 1);
        check("t7_async_words", words_loaded, 0);
        check("t7_async_wdata", mem_wdata, 0);
        wlog_a.delete(); wlog_d.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t7_no_writes", wlog_a.size(), 0);
        check("t7_error", error, 0);

`ifdef BOOT_TIMEOUT_EN
        // Stall in DATA_HI until the watchdog fires.
        img = '{8'h00, 8'h01};
        pulse_start();
        send_image(img, 1'b0);
        check("t8_before_timeout", error, 0);
        repeat (TB_TO + 2) @(negedge clk);
        check("t8_timeout_error", error, 1);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
